// File: rtl/audio_sfx_scheduler.sv
// audio_sfx_scheduler
//   Shares one square-wave tone generator between N_REQ sound-effect
//   requesters. Requests latch into a one-deep pending bit per effect. Fixed
//   priority arbitration picks the lowest set index. Each effect is NOTES
//   notes of NOTE_CLKS clocks, separated by GAP_CLKS clocks of silence.
//   A higher-priority request may take over at a note boundary.
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_req        one-clock request pulses, bit k = effect k
//   o_div        tone half-period in clocks, valid while o_note_en=1
//   o_note_en    generator enable (0 = silence)
//   o_busy       an effect is playing or sitting in a gap
//   o_active_id  index of the current or most recent effect
//   o_done       high during the last clock of an effect's final note
module audio_sfx_scheduler #(
   parameter int N_REQ     = 4,
   parameter int NOTES     = 4,
   parameter int DIV_W     = 16,
   parameter int NOTE_CLKS = 500000,
   parameter int GAP_CLKS  = 50000,
   parameter int BASE_DIV  = 15000,
   parameter int STEP_K    = 2000,
   parameter int STEP_J    = 1000,
   localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   output logic [DIV_W-1:0] o_div,
   output logic             o_note_en,
   output logic             o_busy,
   output logic [ID_W-1:0]  o_active_id,
   output logic             o_done
);

   localparam int MAX_CLKS = (NOTE_CLKS > GAP_CLKS) ? NOTE_CLKS : GAP_CLKS;
   localparam int CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
   localparam int NOTE_W   = (NOTES > 1) ? $clog2(NOTES) : 1;

   localparam logic [CNT_W-1:0]  NOTE_LAST = CNT_W'(NOTE_CLKS - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
   localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(NOTES - 1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t             state_q, state_n;
   logic [N_REQ-1:0]   pend_q, pend_n, clr, below, pend_hi;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [NOTE_W-1:0]  note_q, note_n;
   logic [DIV_W-1:0]   div_q, div_n;
   logic               en_q, en_n, busy_q, busy_n;
   logic [ID_W-1:0]    id_q, id_n, first, pre;

   function automatic logic [DIV_W-1:0] divf(input logic [ID_W-1:0] k, input logic [NOTE_W-1:0] j);
      return DIV_W'(32'(BASE_DIV) + 32'(k) * 32'(STEP_K) + 32'(j) * 32'(STEP_J));
   endfunction

   function automatic logic [ID_W-1:0] lowest(input logic [N_REQ-1:0] v);
      logic [ID_W-1:0] r;
      r = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (v[i]) r = ID_W'(i);
      return r;
   endfunction

   // Only effects with a smaller index than the one playing may take over.
   always_comb begin
      below = '0;
      for (int i = 0; i < N_REQ; i++)
         below[i] = (ID_W'(i) < id_q);
   end

   assign pend_hi = pend_q & below;
   assign first   = lowest(pend_q);
   assign pre     = lowest(pend_hi);

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      note_n  = note_q;
      div_n   = div_q;
      en_n    = en_q;
      busy_n  = busy_q;
      id_n    = id_q;
      clr     = '0;
      case (state_q)
         IDLE: begin
            if (|pend_q) begin
               state_n = PLAY;
               cnt_n   = '0;
               note_n  = '0;
               id_n    = first;
               div_n   = divf(first, '0);
               en_n    = 1'b1;
               busy_n  = 1'b1;
               clr     = N_REQ'(1) << first;
            end
         end
         PLAY: begin
            if (cnt_q != NOTE_LAST) begin
               cnt_n = cnt_q + 1'b1;
            end else begin
               cnt_n = '0;
               if (note_q == LAST_NOTE) begin
                  // Back-to-back effects: a waiting request starts without an idle clock.
                  if (|pend_q) begin
                     note_n = '0;
                     id_n   = first;
                     div_n  = divf(first, '0);
                     en_n   = 1'b1;
                     clr    = N_REQ'(1) << first;
                  end else begin
                     state_n = IDLE;
                     en_n    = 1'b0;
                     busy_n  = 1'b0;
                  end
               end else if (|pend_hi) begin
                  // Takeover: the aborted effect never signals done; the gap
                  // that follows belongs to the new effect.
                  note_n = '0;
                  id_n   = pre;
                  clr    = N_REQ'(1) << pre;
                  if (GAP_CLKS == 0) begin
                     div_n = divf(pre, '0);
                  end else begin
                     state_n = GAP;
                     en_n    = 1'b0;
                  end
               end else begin
                  note_n = note_q + 1'b1;
                  if (GAP_CLKS == 0) begin
                     div_n = divf(id_q, note_q + 1'b1);
                  end else begin
                     state_n = GAP;
                     en_n    = 1'b0;
                  end
               end
            end
         end
         GAP: begin
            if (cnt_q != GAP_LAST) begin
               cnt_n = cnt_q + 1'b1;
            end else begin
               cnt_n   = '0;
               state_n = PLAY;
               div_n   = divf(id_q, note_q);
               en_n    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A request on the granting edge re-arms the bit, so it is served next time.
   assign pend_n = (pend_q & ~clr) | i_req;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         cnt_q   <= '0;
         note_q  <= '0;
         div_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_n;
         pend_q  <= pend_n;
         cnt_q   <= cnt_n;
         note_q  <= note_n;
         div_q   <= div_n;
         en_q    <= en_n;
         busy_q  <= busy_n;
         id_q    <= id_n;
      end
   end

   assign o_div       = div_q;
   assign o_note_en   = en_q;
   assign o_busy      = busy_q;
   assign o_active_id = id_q;
   assign o_done      = (state_q == PLAY) && (cnt_q == NOTE_LAST) && (note_q == LAST_NOTE);

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// tb_audio_sfx_scheduler
//   Drives audio_sfx_scheduler with a fixed vector table, scripted corner
//   sequences and random request traffic. A timeline model predicts the
//   outputs: each effect is placed by its start time, and the note and phase
//   come from division by the note+gap period.
module tb_audio_sfx_scheduler;
   localparam int N_REQ = 4, NOTES = 3, DIV_W = 16, NC = 10, G = 2;
   localparam int BASE = 1000, SK = 200, SJ = 50, L = NC + G;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic [N_REQ-1:0]  i_req;
   logic [DIV_W-1:0]  o_div;
   logic              o_note_en, o_busy, o_done;
   logic [1:0]        o_active_id;

   audio_sfx_scheduler #(
      .N_REQ(N_REQ), .NOTES(NOTES), .DIV_W(DIV_W), .NOTE_CLKS(NC), .GAP_CLKS(G),
      .BASE_DIV(BASE), .STEP_K(SK), .STEP_J(SJ)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_div(o_div),
      .o_note_en(o_note_en), .o_busy(o_busy), .o_active_id(o_active_id), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   int total = 0, bad = 0;
   int t = 0;
   int done_q[$];

   // Timeline model: the current effect, the edge at which its note 0 started,
   // the pending set, and the last divider that was played.
   bit       m_busy;
   int       m_id, m_s, m_last_div;
   bit [3:0] m_pend;
   bit       e_en, e_done;

   typedef struct {
      logic [3:0] req;
      int         n;
      logic       en;
      int         div;
      logic       busy;
      int         id;
      logic       done;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, t);
      end
   endtask

   function automatic int lowest(input bit [3:0] v);
      for (int i = 0; i < N_REQ; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_id = 0; m_s = 0; m_last_div = 0; m_pend = '0;
   endtask

   task automatic model_grant(input int g, input int start);
      m_pend[g] = 1'b0;
      m_busy = 1;
      m_id = g;
      m_s = start;
   endtask

   // Applies the decisions that the edge t makes, based on the clock just ended.
   task automatic model_edge(input logic [3:0] req);
      int p, g;
      p = (t - 1) - m_s;
      if (!m_busy) begin
         if (m_pend != 0) model_grant(lowest(m_pend), t);
      end else if (p >= 0 && (p % L) == NC - 1) begin
         if (p / L == NOTES - 1) begin
            if (m_pend != 0) model_grant(lowest(m_pend), t);
            else m_busy = 0;
         end else begin
            g = lowest(m_pend);
            if (g >= 0 && g < m_id) model_grant(g, t + G);
         end
      end
      m_pend |= req;
   endtask

   task automatic model_out();
      int p, j, r;
      e_en = 0; e_done = 0;
      if (m_busy) begin
         p = t - m_s;
         if (p >= 0) begin
            j = p / L;
            r = p % L;
            e_en = (r < NC);
            e_done = (j == NOTES - 1) && (r == NC - 1);
            if (e_en) m_last_div = BASE + m_id * SK + j * SJ;
         end
      end
   endtask

   task automatic tick(input logic [3:0] req);
      i_req = req;
      @(posedge i_clk);
      t++;
      if (!i_rst_n) model_reset();
      else model_edge(req);
      #1;
      model_out();
      chk("m_en", o_note_en, e_en);
      chk("m_div", o_div, m_last_div);
      chk("m_busy", o_busy, m_busy);
      chk("m_id", o_active_id, m_id);
      chk("m_done", o_done, e_done);
      if (o_done) done_q.push_back(int'(o_active_id));
   endtask

   task automatic run_until_idle(input int max);
      int k;
      k = 0;
      while (o_busy && k < max) begin
         tick(4'b0000);
         k++;
      end
      chk("idle_timeout", o_busy, 1'b0);
   endtask

   task automatic chk_done_ids(input string name, input int a, input int b, input int n);
      chk({name, "_count"}, done_q.size(), n);
      if (done_q.size() == n && n >= 1) chk({name, "_id0"}, done_q[0], a);
      if (done_q.size() == n && n >= 2) chk({name, "_id1"}, done_q[1], b);
   endtask

   initial begin
      int k;
      logic [3:0] rq;
      int r;

      tbl[0] = '{4'b0000,  2, 1'b0,    0, 1'b0, 0, 1'b0};
      tbl[1] = '{4'b0010,  1, 1'b0,    0, 1'b0, 0, 1'b0};
      tbl[2] = '{4'b0000, 10, 1'b1, 1200, 1'b1, 1, 1'b0};
      tbl[3] = '{4'b0000,  2, 1'b0, 1200, 1'b1, 1, 1'b0};
      tbl[4] = '{4'b0000, 10, 1'b1, 1250, 1'b1, 1, 1'b0};
      tbl[5] = '{4'b0000,  2, 1'b0, 1250, 1'b1, 1, 1'b0};
      tbl[6] = '{4'b0000,  9, 1'b1, 1300, 1'b1, 1, 1'b0};
      tbl[7] = '{4'b0000,  1, 1'b1, 1300, 1'b1, 1, 1'b1};
      tbl[8] = '{4'b0000,  2, 1'b0, 1300, 1'b0, 1, 1'b0};
      tbl[9] = '{4'b0000,  1, 1'b0, 1300, 1'b0, 1, 1'b0};

      i_rst_n = 1'b0;
      i_req = '0;
      model_reset();
      repeat (3) tick(4'b0000);
      i_rst_n = 1'b1;

      // Single effect 1, table-driven.
      for (int i = 0; i < 10; i++) begin
         for (int n = 0; n < tbl[i].n; n++) begin
            tick(tbl[i].req);
            chk("tbl_en", o_note_en, tbl[i].en);
            chk("tbl_div", o_div, tbl[i].div);
            chk("tbl_busy", o_busy, tbl[i].busy);
            chk("tbl_id", o_active_id, tbl[i].id);
            chk("tbl_done", o_done, tbl[i].done);
         end
      end

      // Simultaneous 0 and 3: effect 3 follows with no idle clock.
      done_q.delete();
      tick(4'b1001);
      tick(4'b0000);
      k = 0;
      while (!o_done && k < 100) begin
         tick(4'b0000);
         k++;
      end
      chk("simul_done_seen", o_done, 1'b1);
      tick(4'b0000);
      chk("simul_next_div", o_div, 1600);
      chk("simul_next_en", o_note_en, 1'b1);
      chk("simul_next_busy", o_busy, 1'b1);
      chk("simul_next_id", o_active_id, 3);
      run_until_idle(200);
      chk_done_ids("simul", 0, 3, 2);

      // Takeover: effect 2 aborted by effect 0, never signals done.
      done_q.delete();
      tick(4'b0100);
      repeat (3) tick(4'b0000);
      tick(4'b0001);
      run_until_idle(200);
      chk_done_ids("preempt", 0, 0, 1);

      // Lower priority waits for effect 1 to finish.
      done_q.delete();
      tick(4'b0010);
      repeat (5) tick(4'b0000);
      tick(4'b1000);
      run_until_idle(200);
      chk_done_ids("nopreempt", 1, 3, 2);

      // Three re-requests of the playing effect replay it exactly once.
      done_q.delete();
      tick(4'b0010);
      repeat (3) tick(4'b0000);
      tick(4'b0010);
      repeat (10) tick(4'b0000);
      tick(4'b0010);
      repeat (10) tick(4'b0000);
      tick(4'b0010);
      run_until_idle(200);
      chk_done_ids("replay", 1, 1, 2);

      // Reset mid-note clears outputs and the pending request of effect 3.
      done_q.delete();
      tick(4'b0010);
      repeat (4) tick(4'b0000);
      tick(4'b1000);
      repeat (2) tick(4'b0000);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("rst_en", o_note_en, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_div", o_div, 0);
      chk("rst_id", o_active_id, 0);
      repeat (2) tick(4'b0000);
      i_rst_n = 1'b1;
      repeat (20) tick(4'b0000);
      chk("rst_pend_gone", o_busy, 1'b0);
      tick(4'b0100);
      tick(4'b0000);
      run_until_idle(200);
      chk_done_ids("after_rst", 2, 0, 1);

      // Random traffic against the timeline model.
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 63);
         rq = 4'b0000;
         if (r < 4) rq[r] = 1'b1;
         else if (r == 4) rq = 4'($urandom_range(0, 15));
         tick(rq);
      end
      run_until_idle(500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
